// File: rtl/fc_layer_param.sv
// Fully-connected layer engine: BEATS input vectors of K int8 activations are
// multiplied against NOUT weight rows on parallel MAC lanes (one MAC per lane
// per cycle), seeded with bias, then requantised to int8 and handed off over
// a valid/ready output handshake.
module fc_layer_param #(
   parameter int unsigned K      = 9,
   parameter int unsigned NOUT   = 2,
   parameter int unsigned BEATS  = 32,
   parameter int unsigned ACC_W  = 32,
   parameter int unsigned BIAS_W = 16,
   parameter int unsigned M0     = 11,
   parameter int unsigned SHIFT  = 15,
   parameter int unsigned RELU   = 0
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     valid_i,
   output logic                     ready_o,
   input  logic [K*8-1:0]           data_in,
   input  logic [NOUT*K*8-1:0]      weight_in,
   input  logic [NOUT*BIAS_W-1:0]   bias_in,
   output logic                     valid_o,
   input  logic                     ready_i,
   output logic [NOUT*8-1:0]        data_o
);

   localparam int unsigned PW = ACC_W + 16;
   localparam int unsigned IW = (K > 1) ? $clog2(K) : 1;
   localparam int unsigned BW = (BEATS > 1) ? $clog2(BEATS) : 1;

   // Rounding constant: half an LSB of the shifted result (round half up).
   localparam logic signed [PW-1:0] RND  = PW'(1) << (SHIFT - 1);
   localparam logic signed [PW-1:0] SMAX = PW'(127);
   localparam logic signed [PW-1:0] SMIN = -PW'(128);

   typedef enum logic [1:0] {StIdle, StMac, StRq, StOut} state_t;

   state_t                   state;
   logic [IW-1:0]            idx;
   logic [BW-1:0]            beat;
   logic signed [7:0]        act [K];
   logic signed [7:0]        wgt [NOUT][K];
   logic signed [ACC_W-1:0]  acc [NOUT];
   logic signed [15:0]       prod [NOUT];
   logic [7:0]               rq [NOUT];

   // acc * M0, round, shift, optional ReLU, saturate to int8.
   function automatic logic [7:0] requant(input logic signed [ACC_W-1:0] a);
      logic signed [PW-1:0] p;
      logic signed [PW-1:0] s;
      logic signed [PW-1:0] r;
      p = PW'(a) * $signed(PW'(M0));
      s = p + RND;
      r = s >>> SHIFT;
      if ((RELU != 0) && (r < 0)) r = '0;
      if (r > SMAX) r = SMAX;
      else if (r < SMIN) r = SMIN;
      return r[7:0];
   endfunction

   // Per-lane product of the current element and requantised lane results.
   always_comb begin
      for (int n = 0; n < NOUT; n++) begin
         prod[n] = 16'(act[idx]) * 16'(wgt[n][idx]);
         rq[n]   = requant(acc[n]);
      end
   end

   // Control FSM, datapath registers and registered handshake outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= StIdle;
         idx     <= '0;
         beat    <= '0;
         valid_o <= 1'b0;
         ready_o <= 1'b1;
         data_o  <= '0;
         for (int n = 0; n < NOUT; n++) begin
            acc[n] <= '0;
            for (int i = 0; i < K; i++) wgt[n][i] <= '0;
         end
         for (int i = 0; i < K; i++) act[i] <= '0;
      end else begin
         unique case (state)
            StIdle: begin
               if (valid_i) begin
                  for (int i = 0; i < K; i++) begin
                     act[i] <= data_in[i*8 +: 8];
                     for (int n = 0; n < NOUT; n++) wgt[n][i] <= weight_in[(n*K+i)*8 +: 8];
                  end
                  // Bias seeds the accumulators only at the start of an inference.
                  if (beat == '0) begin
                     for (int n = 0; n < NOUT; n++)
                        acc[n] <= ACC_W'($signed(bias_in[n*BIAS_W +: BIAS_W]));
                  end
                  idx     <= '0;
                  ready_o <= 1'b0;
                  state   <= StMac;
               end
            end
            StMac: begin
               for (int n = 0; n < NOUT; n++)
                  acc[n] <= acc[n] + {{(ACC_W-16){prod[n][15]}}, prod[n]};
               if (idx == IW'(K - 1)) begin
                  if (beat == BW'(BEATS - 1)) begin
                     state <= StRq;
                  end else begin
                     beat    <= beat + 1'b1;
                     ready_o <= 1'b1;
                     state   <= StIdle;
                  end
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            StRq: begin
               for (int n = 0; n < NOUT; n++) data_o[n*8 +: 8] <= rq[n];
               valid_o <= 1'b1;
               state   <= StOut;
            end
            StOut: begin
               if (ready_i) begin
                  valid_o <= 1'b0;
                  beat    <= '0;
                  ready_o <= 1'b1;
                  state   <= StIdle;
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_fc_layer_param.sv
// Randomised bench for fc_layer_param: a driver issues inferences and pushes
// the reference result into a queue; a monitor pops and compares on each
// output handshake.
module tb_fc_layer_param;

   localparam int unsigned K      = 9;
   localparam int unsigned NOUT   = 2;
   localparam int unsigned BEATS  = 32;
   localparam int unsigned ACC_W  = 32;
   localparam int unsigned BIAS_W = 16;
   localparam int unsigned M0     = 11;
   localparam int unsigned SHIFT  = 15;
   localparam int unsigned RELU   = 0;

   logic                   clk = 1'b0;
   logic                   rst_n;
   logic                   valid_i;
   logic                   ready_o;
   logic [K*8-1:0]         data_in;
   logic [NOUT*K*8-1:0]    weight_in;
   logic [NOUT*BIAS_W-1:0] bias_in;
   logic                   valid_o;
   logic                   ready_i;
   logic [NOUT*8-1:0]      data_o;

   always #5 clk = ~clk;

   fc_layer_param #(
      .K(K), .NOUT(NOUT), .BEATS(BEATS), .ACC_W(ACC_W), .BIAS_W(BIAS_W),
      .M0(M0), .SHIFT(SHIFT), .RELU(RELU)
   ) dut (
      .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .ready_o(ready_o),
      .data_in(data_in), .weight_in(weight_in), .bias_in(bias_in),
      .valid_o(valid_o), .ready_i(ready_i), .data_o(data_o)
   );

   int checks = 0;
   int errors = 0;
   logic [NOUT*8-1:0] exp_q [$];

   logic signed [7:0]  s_act  [BEATS][K];
   logic signed [7:0]  s_w    [BEATS][NOUT][K];
   logic signed [15:0] s_bias [BEATS][NOUT];

   task automatic check(input string name, input longint actual, input longint required);
      checks++;
      if (actual != required) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, required, $time);
      end
   endtask

   // Reference: bias of beat 0 plus dot product, wrapped to 32 bits, then requant.
   function automatic logic [NOUT*8-1:0] model();
      logic [NOUT*8-1:0] res;
      int     acc;
      longint p;
      longint r;
      res = '0;
      for (int n = 0; n < NOUT; n++) begin
         acc = int'(s_bias[0][n]);
         for (int b = 0; b < BEATS; b++)
            for (int i = 0; i < K; i++)
               acc += int'(s_act[b][i]) * int'(s_w[b][n][i]);
         p = longint'(acc) * longint'(M0);
         r = (p + (longint'(1) <<< (SHIFT - 1))) >>> SHIFT;
         if (RELU != 0 && r < 0) r = 0;
         if (r > 127) r = 127;
         if (r < -128) r = -128;
         res[n*8 +: 8] = 8'(r);
      end
      return res;
   endfunction

   // mode 0: random; 1: saturating extremes; 2: zero data, bias-only on beat 0.
   task automatic fill(input int mode);
      for (int b = 0; b < BEATS; b++) begin
         for (int n = 0; n < NOUT; n++) s_bias[b][n] = 16'($urandom);
         if (mode == 2 && b == 0) begin
            s_bias[b][0] = 16'sd3000;
            s_bias[b][1] = -16'sd3000;
         end
         for (int i = 0; i < K; i++) begin
            s_act[b][i] = (mode == 1) ? 8'sd127 : (mode == 2) ? 8'sd0 : 8'($urandom);
            for (int n = 0; n < NOUT; n++)
               s_w[b][n][i] = (mode == 1) ? ((n == 0) ? 8'sd127 : -8'sd128) : 8'($urandom);
         end
      end
   endtask

   task automatic send_beat(input int b, input bit first);
      int n;
      for (int i = 0; i < K; i++) begin
         data_in[i*8 +: 8] = s_act[b][i];
         for (int j = 0; j < NOUT; j++) weight_in[(j*K+i)*8 +: 8] = s_w[b][j][i];
      end
      for (int j = 0; j < NOUT; j++) bias_in[j*BIAS_W +: BIAS_W] = s_bias[b][j];
      valid_i = 1'b1;
      n = 0;
      while (!ready_o && n < 60) begin
         @(posedge clk); #1;
         n++;
      end
      if (!ready_o) begin
         check("accept_timeout", 0, 1);
         return;
      end
      if (!first) check("ready_low_cycles", n, K);
      @(posedge clk); #1;
   endtask

   task automatic run_inf(input int mode, input bit bp);
      logic [NOUT*8-1:0] e;
      int n;
      fill(mode);
      e = model();
      for (int b = 0; b < BEATS; b++) send_beat(b, b == 0);
      exp_q.push_back(e);
      if (bp) ready_i = 1'b0;
      n = 0;
      while (!valid_o && n < 60) begin
         @(posedge clk); #1;
         n++;
      end
      check("valid_latency", n, K + 1);
      if (bp) begin
         for (int c = 0; c < 5; c++) begin
            check("bp_valid", valid_o, 1);
            check("bp_data", data_o, e);
            check("bp_ready", ready_o, 0);
            valid_i = 1'($urandom);
            data_in = {K{8'($urandom)}};
            @(posedge clk); #1;
         end
         valid_i = 1'b0;
         check("bp_data_end", data_o, e);
         ready_i = 1'b1;
         @(posedge clk); #1;
         check("bp_valid_drop", valid_o, 0);
         check("bp_ready_rise", ready_o, 1);
      end
   endtask

   // Scoreboard monitor: compare on every output handshake.
   always @(negedge clk) begin
      if (rst_n && valid_o && ready_i) begin
         if (exp_q.size() == 0) check("unexpected_result", 1, 0);
         else check("result", data_o, exp_q.pop_front());
      end
   end

   initial begin
      int n;
      rst_n     = 1'b0;
      valid_i   = 1'b0;
      ready_i   = 1'b1;
      data_in   = '0;
      weight_in = '0;
      bias_in   = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_valid", valid_o, 0);
      check("reset_data", data_o, 0);
      check("reset_ready", ready_o, 1);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;

      run_inf(1, 1'b0);
      run_inf(2, 1'b0);
      run_inf(0, 1'b1);
      repeat (3) run_inf(0, 1'b0);
      valid_i = 1'b0;

      // Abort an inference mid-MAC; the next one must start from beat 0.
      fill(0);
      for (int b = 0; b < 4; b++) send_beat(b, b == 0);
      valid_i = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      check("abort_ready", ready_o, 1);
      check("abort_valid", valid_o, 0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      run_inf(0, 1'b0);

      repeat (4) run_inf(0, 1'($urandom));
      valid_i = 1'b0;

      n = 0;
      while (exp_q.size() != 0 && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      check("queue_drained", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
